// File: rtl/crc5_nibble_framer.sv
// Byte-to-nibble framer: emits each byte low nibble first, runs CRC-5 (x^5+x^2+1)
// over the payload nibbles and appends the CRC as two trailer nibbles.
module crc5_nibble_framer #(
   parameter logic [4:0] CRC_INIT = 5'h00,
   parameter int         LEN_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [3:0]       m_nibble,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic [4:0]       crc_out,
   output logic             crc_valid,
   output logic [LEN_W-1:0] frame_len,
   output logic             len_overflow
);

   // state   | meaning
   // S_IDLE  | waiting for a byte, s_ready high
   // S_LO    | presenting byte[3:0]
   // S_HI    | presenting byte[7:4]
   // S_CRC_A | presenting crc[4:1]
   // S_CRC_B | presenting {crc[0],3'b000}, final nibble of frame
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LO    = 3'd1,
      S_HI    = 3'd2,
      S_CRC_A = 3'd3,
      S_CRC_B = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_byte;
   logic             r_last;
   logic [4:0]       r_crc;
   logic [LEN_W-1:0] r_cnt;
   logic             r_rdy_en;
   logic [4:0]       r_crc_out;
   logic             r_crc_valid;
   logic [LEN_W-1:0] r_frame_len;
   logic             r_len_ovf;

   logic             w_s_hs;
   logic             w_m_hs;
   logic [3:0]       w_pay_nib;
   logic [4:0]       w_crc_nxt;

   always_comb begin
      w_state_nxt = r_state;
      s_ready     = 1'b0;
      m_valid     = 1'b0;
      m_last      = 1'b0;
      m_nibble    = 4'h0;
      w_pay_nib   = r_byte[3:0];
      case (r_state)
         S_IDLE: begin
            s_ready = r_rdy_en;
            if (s_valid && r_rdy_en) w_state_nxt = S_LO;
         end
         S_LO: begin
            m_nibble = r_byte[3:0];
            m_valid  = 1'b1;
            if (m_ready) w_state_nxt = S_HI;
         end
         S_HI: begin
            m_nibble  = r_byte[7:4];
            m_valid   = 1'b1;
            w_pay_nib = r_byte[7:4];
            if (m_ready) w_state_nxt = r_last ? S_CRC_A : S_IDLE;
         end
         S_CRC_A: begin
            m_nibble = r_crc[4:1];
            m_valid  = 1'b1;
            if (m_ready) w_state_nxt = S_CRC_B;
         end
         S_CRC_B: begin
            m_nibble = {r_crc[0], 3'b000};
            m_valid  = 1'b1;
            m_last   = 1'b1;
            if (m_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_s_hs = s_valid && s_ready;
   assign w_m_hs = m_valid && m_ready;

   // Four serial MSB-first steps of the LFSR folded into one parallel update.
   assign w_crc_nxt[4] = r_crc[0] ^ r_crc[3] ^ w_pay_nib[2];
   assign w_crc_nxt[3] = r_crc[4] ^ r_crc[2] ^ w_pay_nib[3] ^ w_pay_nib[1];
   assign w_crc_nxt[2] = r_crc[4] ^ r_crc[3] ^ r_crc[1] ^ w_pay_nib[3] ^ w_pay_nib[2]
                         ^ w_pay_nib[0];
   assign w_crc_nxt[1] = r_crc[2] ^ w_pay_nib[1];
   assign w_crc_nxt[0] = r_crc[4] ^ r_crc[1] ^ w_pay_nib[3] ^ w_pay_nib[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_byte      <= 8'h00;
         r_last      <= 1'b0;
         r_crc       <= CRC_INIT;
         r_cnt       <= '0;
         r_rdy_en    <= 1'b0;
         r_crc_out   <= CRC_INIT;
         r_crc_valid <= 1'b0;
         r_frame_len <= '0;
         r_len_ovf   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rdy_en    <= 1'b1;
         r_crc_valid <= 1'b0;
         if (w_s_hs) begin
            r_byte <= s_data;
            r_last <= s_last;
            if (r_cnt != LEN_MAX) r_cnt <= r_cnt + 1'b1;
         end
         if (w_m_hs) begin
            case (r_state)
               S_LO, S_HI: r_crc <= w_crc_nxt;
               S_CRC_B: begin
                  r_crc_out   <= r_crc;
                  r_crc_valid <= 1'b1;
                  r_frame_len <= r_cnt;
                  r_len_ovf   <= (r_cnt == LEN_MAX);
                  r_crc       <= CRC_INIT;
                  r_cnt       <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign crc_out      = r_crc_out;
   assign crc_valid    = r_crc_valid;
   assign frame_len    = r_frame_len;
   assign len_overflow = r_len_ovf;

endmodule

// File: tb/tb_crc5_nibble_framer.sv
// Bench for crc5_nibble_framer: frame-level model (nibble queue, CRC by polynomial
// long division) checked every cycle, plus directed frames with literal results.
module tb_crc5_nibble_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       m_ready = 1'b1;

   logic       s_ready, m_valid, m_last, crc_valid, len_overflow;
   logic [3:0] m_nibble;
   logic [4:0] crc_out;
   logic [7:0] frame_len;

   logic       d2_s_ready, d2_m_valid, d2_m_last, d2_crc_valid, d2_len_ovf;
   logic [3:0] d2_m_nibble;
   logic [4:0] d2_crc_out;
   logic [1:0] d2_frame_len;

   crc5_nibble_framer u_dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .m_nibble(m_nibble), .m_valid(m_valid), .m_last(m_last),
      .m_ready(m_ready), .crc_out(crc_out), .crc_valid(crc_valid),
      .frame_len(frame_len), .len_overflow(len_overflow)
   );

   crc5_nibble_framer #(.LEN_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(d2_s_ready), .m_nibble(d2_m_nibble), .m_valid(d2_m_valid),
      .m_last(d2_m_last), .m_ready(m_ready), .crc_out(d2_crc_out),
      .crc_valid(d2_crc_valid), .frame_len(d2_frame_len), .len_overflow(d2_len_ovf)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0] q_nib[$];
   bit         q_last[$];
   logic [7:0] frame[$];
   bit         en = 1'b0;
   logic [4:0] e_crc = 5'h00;
   bit         e_cv = 1'b0;
   logic [7:0] e_len = 8'h00;
   bit         e_ovf = 1'b0;
   logic [1:0] e_len2 = 2'h0;
   bit         e_ovf2 = 1'b0;
   logic [4:0] p_crc = 5'h00;
   int         p_n = 0;

   function automatic logic [4:0] crc_ref(input logic [7:0] b[$]);
      bit         m[$];
      bit [5:0]   poly;
      logic [4:0] r;
      poly = 6'b100101;
      foreach (b[i]) begin
         for (int k = 3; k >= 0; k--) m.push_back(b[i][k]);
         for (int k = 7; k >= 4; k--) m.push_back(b[i][k]);
      end
      repeat (5) m.push_back(1'b0);
      for (int i = 0; i + 5 < m.size(); i++)
         if (m[i]) for (int k = 0; k < 6; k++) m[i+k] = m[i+k] ^ poly[5-k];
      r = 5'h00;
      for (int j = m.size() - 5; j < m.size(); j++) r = {r[3:0], m[j]};
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit rdy;
      if (rst) begin
         q_nib.delete(); q_last.delete(); frame.delete();
         en = 1'b0; e_crc = 5'h00; e_cv = 1'b0;
         e_len = 8'h00; e_ovf = 1'b0; e_len2 = 2'h0; e_ovf2 = 1'b0;
      end else begin
         rdy  = en && (q_nib.size() == 0);
         e_cv = 1'b0;
         if (q_nib.size() > 0 && m_ready) begin
            if (q_last[0]) begin
               e_crc  = p_crc;
               e_cv   = 1'b1;
               e_len  = (p_n >= 255) ? 8'd255 : 8'(p_n);
               e_ovf  = (p_n >= 255);
               e_len2 = (p_n >= 3) ? 2'd3 : 2'(p_n);
               e_ovf2 = (p_n >= 3);
            end
            void'(q_nib.pop_front());
            void'(q_last.pop_front());
         end
         if (rdy && s_valid) begin
            frame.push_back(s_data);
            q_nib.push_back(s_data[3:0]); q_last.push_back(1'b0);
            q_nib.push_back(s_data[7:4]); q_last.push_back(1'b0);
            if (s_last) begin
               p_crc = crc_ref(frame);
               p_n   = frame.size();
               q_nib.push_back(p_crc[4:1]);         q_last.push_back(1'b0);
               q_nib.push_back({p_crc[0], 3'b000}); q_last.push_back(1'b1);
               frame.delete();
            end
         end
         en = 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [3:0] obs[$];
   int         cv_cnt = 0;

   always @(negedge clk) begin
      bit exp_mv;
      bit exp_sr;
      exp_mv = (q_nib.size() > 0);
      exp_sr = !rst && en && (q_nib.size() == 0);
      chk("s_ready", s_ready, exp_sr);
      chk("m_valid", m_valid, exp_mv);
      if (exp_mv) begin
         chk("m_nibble", m_nibble, q_nib[0]);
         chk("m_last", m_last, q_last[0]);
      end
      chk("crc_valid", crc_valid, e_cv);
      chk("crc_out", crc_out, e_crc);
      chk("frame_len", frame_len, e_len);
      chk("len_overflow", len_overflow, e_ovf);
      chk("d2_s_ready", d2_s_ready, exp_sr);
      chk("d2_m_valid", d2_m_valid, exp_mv);
      if (exp_mv) begin
         chk("d2_m_nibble", d2_m_nibble, q_nib[0]);
         chk("d2_m_last", d2_m_last, q_last[0]);
      end
      chk("d2_crc_valid", d2_crc_valid, e_cv);
      chk("d2_crc_out", d2_crc_out, e_crc);
      chk("d2_frame_len", d2_frame_len, e_len2);
      chk("d2_len_overflow", d2_len_ovf, e_ovf2);
      if (crc_valid) cv_cnt++;
      if (m_valid && m_ready) obs.push_back(m_nibble);
   end

   // ---------------- m_ready driver ----------------
   int mr_mode = 0;
   int mr_ph = 0;
   always @(posedge clk) begin
      #1;
      case (mr_mode)
         0: m_ready = 1'b1;
         1: m_ready = 1'($urandom_range(0, 1));
         default: begin
            m_ready = (mr_ph == 3);
            mr_ph   = (mr_ph + 1) % 4;
         end
      endcase
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] d, input bit last);
      int t;
      t = 0;
      s_data = d; s_last = last; s_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 300) begin
            tests++; fails++;
            $display("FAIL send_timeout: byte %0h not accepted", d);
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] b[$]);
      foreach (b[i]) send_byte(b[i], i == b.size() - 1);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (q_nib.size() != 0) begin
         @(posedge clk); #1;
         t++;
         if (t > 3000) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d nibbles pending", q_nib.size());
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pack_obs();
      logic [31:0] v;
      v = 32'h0;
      foreach (obs[i]) v = {v[27:0], obs[i]};
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] fr[$];

      chk("model_crc_01", crc_ref('{8'h01}), 5'h1A);
      chk("model_crc_10", crc_ref('{8'h10}), 5'h05);
      chk("model_crc_0000", crc_ref('{8'h00, 8'h00}), 5'h00);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_crc_out", crc_out, 5'h00);
      rst = 1'b0;
      @(posedge clk); #1;

      // single byte 0x01
      obs.delete(); cv_cnt = 0;
      send_frame('{8'h01}); wait_drain();
      chk("c1_nibbles", pack_obs(), 32'h10D0);
      chk("c1_crc", crc_out, 5'h1A);
      chk("c1_len", frame_len, 8'd1);
      chk("c1_pulses", cv_cnt, 1);

      // single byte 0x10, crc held afterwards
      obs.delete();
      send_frame('{8'h10}); wait_drain();
      chk("c2_nibbles", pack_obs(), 32'h0128);
      repeat (5) @(posedge clk);
      #1;
      chk("c2_crc_held", crc_out, 5'h05);
      chk("c2_no_pulse", crc_valid, 1'b0);

      // two zero bytes
      obs.delete();
      send_frame('{8'h00, 8'h00}); wait_drain();
      chk("c3_count", obs.size(), 6);
      chk("c3_nibbles", pack_obs(), 32'h0);
      chk("c3_crc", crc_out, 5'h00);
      chk("c3_len", frame_len, 8'd2);

      // backpressure: three stalled cycles per nibble
      mr_ph = 0; mr_mode = 2;
      obs.delete(); cv_cnt = 0;
      send_frame('{8'h01}); wait_drain();
      mr_mode = 0;
      @(posedge clk); #1;
      chk("c4_nibbles", pack_obs(), 32'h10D0);
      chk("c4_crc", crc_out, 5'h1A);
      chk("c4_pulses", cv_cnt, 1);

      // saturation on the narrow counter
      send_frame('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}); wait_drain();
      chk("c5_len2", d2_frame_len, 2'd3);
      chk("c5_ovf2", d2_len_ovf, 1'b1);
      chk("c5_len8", frame_len, 8'd5);
      send_frame('{8'hA5}); wait_drain();
      chk("c5_len2_next", d2_frame_len, 2'd1);
      chk("c5_ovf2_next", d2_len_ovf, 1'b0);

      // reset during HI of a 3-byte frame
      cv_cnt = 0;
      send_byte(8'h5A, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1; #2; rst = 1'b0;
      @(negedge clk);
      chk("c6_crc_rst", crc_out, 5'h00);
      chk("c6_len_rst", frame_len, 8'd0);
      @(posedge clk); #1;
      obs.delete();
      send_frame('{8'h01}); wait_drain();
      chk("c6_nibbles", pack_obs(), 32'h10D0);
      chk("c6_crc", crc_out, 5'h1A);
      chk("c6_pulses", cv_cnt, 1);

      // randomized frames with random gaps and backpressure
      mr_mode = 1;
      for (int f = 0; f < 40; f++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int b = 0; b < n; b++) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
            send_byte(8'($urandom), b == n - 1);
         end
      end
      wait_drain();
      mr_mode = 0;

      // long frame saturating the 8-bit counter
      fr.delete();
      for (int i = 0; i < 260; i++) fr.push_back(8'($urandom));
      send_frame(fr); wait_drain();
      chk("long_len", frame_len, 8'd255);
      chk("long_ovf", len_overflow, 1'b1);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
